// File: rtl/mem_access_stage_if.sv
// Purpose: data-bus bundle between the memory stage (master) and the data memory (slave).
// Latency: none, wires only.
// Backpressure: request is held by the master until dresp_addr_ok; dresp_data_ok closes the access.
// Signals: dreq_* carry the request (valid, write, aligned address, byte strobes, lane-shifted data);
//          dresp_* carry the reply (address accepted, data returned or store complete, raw 64-bit word).
interface mem_access_stage_if #(
    parameter int XLEN = 64
);
    logic            dreq_valid;
    logic            dreq_write;
    logic [XLEN-1:0] dreq_addr;
    logic [7:0]      dreq_strobe;
    logic [XLEN-1:0] dreq_data;
    logic            dresp_addr_ok;
    logic            dresp_data_ok;
    logic [XLEN-1:0] dresp_data;

    modport master (
        output dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data
    );

    modport slave (
        input  dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data
    );
endinterface

// File: rtl/mem_access_stage.sv
// Purpose: RV64 memory stage; issues loads/stores on the data bus, extends load data, emits writeback + forward bundles.
// Latency: non-memory / dropped ops 1 cycle after accept; bus ops 1 cycle after dresp_data_ok (2 cycles minimum).
// Backpressure: in_ready only in IDLE; stall_req high while an access is in flight or one is being accepted.
// Ports: clk/reset (sync, active-high); in_* execute bundle with in_valid/in_ready; dbus master side of the
//        data bus; out_* writeback bundle (out_valid pulse); fwd_* forward bundle; stall_req; misalign pulse.
module mem_access_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_memread,
    input  logic                  in_memwrite,
    input  logic                  in_regwrite,
    input  logic [2:0]            in_funct3,
    input  logic [REG_ADDR_W-1:0] in_dst,
    input  logic [XLEN-1:0]       in_addr,
    input  logic [XLEN-1:0]       in_wdata,
    mem_access_stage_if.master    dbus,
    output logic                  out_valid,
    output logic                  out_regwrite,
    output logic [REG_ADDR_W-1:0] out_dst,
    output logic [XLEN-1:0]       out_data,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_dst,
    output logic [XLEN-1:0]       fwd_data,
    output logic                  stall_req,
    output logic                  misalign
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    typedef struct packed {
        logic                  load;
        logic                  store;
        logic                  regwrite;
        logic [2:0]            funct3;
        logic [REG_ADDR_W-1:0] dst;
        logic [XLEN-1:0]       addr;
        logic [XLEN-1:0]       wdata;
    } instr_t;

    state_t                state_q, state_d;
    instr_t                instr_q, instr_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_regwrite_q, out_regwrite_d;
    logic [REG_ADDR_W-1:0] out_dst_q, out_dst_d;
    logic [XLEN-1:0]       out_data_q, out_data_d;
    logic                  misalign_q, misalign_d;

    logic            accept, in_is_mem, in_bad_f3, in_misaligned, go_req, complete;
    logic [2:0]      lane;
    logic [5:0]      shamt;
    logic [XLEN-1:0] load_raw, load_ext;
    logic [7:0]      size_mask;

    // Input classification: funct3=111 is an illegal size and is dropped before the alignment check.
    always_comb begin
        in_misaligned = 1'b0;
        case (in_funct3[1:0])
            2'b01:   in_misaligned = in_addr[0];
            2'b10:   in_misaligned = |in_addr[1:0];
            2'b11:   in_misaligned = |in_addr[2:0];
            default: in_misaligned = 1'b0;
        endcase
    end

    assign accept    = in_valid && (state_q == S_IDLE);
    assign in_is_mem = in_memread | in_memwrite;
    assign in_bad_f3 = (in_funct3 == 3'b111);
    assign go_req    = accept & in_is_mem & ~in_bad_f3 & ~in_misaligned;

    // Load extraction from the latched byte lane of the returned 64-bit word.
    assign lane     = instr_q.addr[2:0];
    assign shamt    = {lane, 3'b000};
    assign load_raw = dbus.dresp_data >> shamt;

    always_comb begin
        load_ext = load_raw;
        case (instr_q.funct3)
            3'b000:  load_ext = {{(XLEN-8){load_raw[7]}},   load_raw[7:0]};
            3'b001:  load_ext = {{(XLEN-16){load_raw[15]}}, load_raw[15:0]};
            3'b010:  load_ext = {{(XLEN-32){load_raw[31]}}, load_raw[31:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}},  load_raw[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, load_raw[15:0]};
            3'b110:  load_ext = {{(XLEN-32){1'b0}}, load_raw[31:0]};
            default: load_ext = load_raw;
        endcase
    end

    always_comb begin
        size_mask = 8'hFF;
        case (instr_q.funct3[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Request fields come straight from the instruction latch, so they stay stable until addr_ok.
    assign dbus.dreq_valid  = (state_q == S_REQ);
    assign dbus.dreq_write  = instr_q.store;
    assign dbus.dreq_addr   = {instr_q.addr[XLEN-1:3], 3'b000};
    assign dbus.dreq_strobe = instr_q.store ? 8'(size_mask << lane) : 8'h00;
    assign dbus.dreq_data   = instr_q.wdata << shamt;

    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        out_valid_d    = 1'b0;
        out_regwrite_d = out_regwrite_q;
        out_dst_d      = out_dst_q;
        out_data_d     = out_data_q;
        misalign_d     = 1'b0;
        complete       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    instr_d.load     = in_memread;
                    instr_d.store    = in_memwrite & ~in_memread;
                    instr_d.regwrite = in_regwrite;
                    instr_d.funct3   = in_funct3;
                    instr_d.dst      = in_dst;
                    instr_d.addr     = in_addr;
                    instr_d.wdata    = in_wdata;
                    if (go_req) begin
                        state_d = S_REQ;
                    end else begin
                        // ALU result, or a dropped memory op that must not write rd.
                        out_valid_d    = 1'b1;
                        out_dst_d      = in_dst;
                        out_data_d     = in_addr;
                        out_regwrite_d = in_regwrite & ~in_is_mem;
                        misalign_d     = in_is_mem & ~in_bad_f3 & in_misaligned;
                    end
                end
            end
            S_REQ: begin
                if (dbus.dresp_addr_ok) begin
                    if (dbus.dresp_data_ok) begin
                        state_d  = S_IDLE;
                        complete = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dbus.dresp_data_ok) begin
                    state_d  = S_IDLE;
                    complete = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            out_valid_d    = 1'b1;
            out_dst_d      = instr_q.dst;
            out_regwrite_d = instr_q.load & instr_q.regwrite;
            out_data_d     = instr_q.load ? load_ext : instr_q.addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            instr_q        <= '0;
            out_valid_q    <= 1'b0;
            out_regwrite_q <= 1'b0;
            out_dst_q      <= '0;
            out_data_q     <= '0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            out_valid_q    <= out_valid_d;
            out_regwrite_q <= out_regwrite_d;
            out_dst_q      <= out_dst_d;
            out_data_q     <= out_data_d;
            misalign_q     <= misalign_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign stall_req    = (state_q != S_IDLE) | go_req;
    assign out_valid    = out_valid_q;
    assign out_regwrite = out_regwrite_q;
    assign out_dst      = out_dst_q;
    assign out_data     = out_data_q;
    assign misalign     = misalign_q;
    // Writeback only happens after the access completes, so a forward never overlaps an in-flight access.
    assign fwd_valid    = out_valid_q & out_regwrite_q & (out_dst_q != '0);
    assign fwd_dst      = out_dst_q;
    assign fwd_data     = out_data_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Purpose: self-checking bench for mem_access_stage with a bus responder and a byte-level reference model.
// Latency: n/a.
// Backpressure: the responder delays addr_ok/data_ok by chosen cycle counts.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, in_ready, in_memread, in_memwrite, in_regwrite;
    logic [2:0]  in_funct3;
    logic [4:0]  in_dst, out_dst, fwd_dst;
    logic [63:0] in_addr, in_wdata, out_data, fwd_data;
    logic        out_valid, out_regwrite, fwd_valid, stall_req, misalign;

    mem_access_stage_if #(.XLEN(64)) dbus ();

    mem_access_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_memread(in_memread), .in_memwrite(in_memwrite), .in_regwrite(in_regwrite),
        .in_funct3(in_funct3), .in_dst(in_dst), .in_addr(in_addr), .in_wdata(in_wdata),
        .dbus(dbus),
        .out_valid(out_valid), .out_regwrite(out_regwrite), .out_dst(out_dst), .out_data(out_data),
        .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
        .stall_req(stall_req), .misalign(misalign)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of one transaction, cycle 1 = first cycle after the accepting edge.
    logic        obs_ready;
    int          obs_vcyc, obs_pulses, obs_req, obs_stall, obs_mis, obs_mis_cyc;
    logic        obs_changed, obs_rw, obs_fwd, obs_write;
    logic [4:0]  obs_dst, obs_fwd_dst;
    logic [63:0] obs_data, obs_fwd_data, obs_daddr, obs_ddata;
    logic [7:0]  obs_strobe;

    // Reference: assemble the loaded value byte by byte, then extend by the access size.
    function automatic logic [63:0] exp_load(input logic [63:0] w, input logic [63:0] addr, input logic [2:0] f3);
        int off;
        int sz;
        logic [63:0] v;
        off = int'(addr % 64'd8);
        sz  = 1 << f3[1:0];
        v   = 64'd0;
        for (int i = 0; i < sz; i++) v = v | (64'(w[8*(off+i) +: 8]) << (8*i));
        if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
        return v;
    endfunction

    function automatic logic [7:0] exp_strobe(input logic [63:0] addr, input logic [2:0] f3);
        int off;
        int sz;
        logic [7:0] s;
        off = int'(addr % 64'd8);
        sz  = 1 << f3[1:0];
        s   = 8'd0;
        for (int i = 0; i < sz; i++) s[off+i] = 1'b1;
        return s;
    endfunction

    task automatic run_op(input logic rd, input logic wr, input logic rw, input logic [2:0] f3,
                          input logic [4:0] dst, input logic [63:0] addr, input logic [63:0] wdata,
                          input int a, input int d, input logic [63:0] resp);
        int wait_cnt;
        @(negedge clk);
        in_valid = 1'b1; in_memread = rd; in_memwrite = wr; in_regwrite = rw;
        in_funct3 = f3; in_dst = dst; in_addr = addr; in_wdata = wdata;
        #1 obs_ready = in_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        obs_vcyc = -1; obs_pulses = 0; obs_req = 0; obs_stall = 0; obs_mis = 0; obs_mis_cyc = -1;
        obs_changed = 1'b0; wait_cnt = 0;
        for (int c = 1; c <= a + d + 5; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (dbus.dreq_valid) begin
                obs_req++;
                if (obs_req == 1) begin
                    obs_daddr = dbus.dreq_addr; obs_strobe = dbus.dreq_strobe;
                    obs_ddata = dbus.dreq_data; obs_write = dbus.dreq_write;
                end else if (obs_daddr !== dbus.dreq_addr || obs_strobe !== dbus.dreq_strobe ||
                             obs_ddata !== dbus.dreq_data || obs_write !== dbus.dreq_write) begin
                    obs_changed = 1'b1;
                end
            end
            if (stall_req) obs_stall++;
            if (misalign) begin obs_mis++; obs_mis_cyc = c; end
            if (out_valid) begin
                obs_pulses++;
                if (obs_vcyc < 0) begin
                    obs_vcyc = c; obs_rw = out_regwrite; obs_dst = out_dst; obs_data = out_data;
                    obs_fwd = fwd_valid; obs_fwd_dst = fwd_dst; obs_fwd_data = fwd_data;
                end
            end
            dbus.dresp_addr_ok = 1'b0;
            dbus.dresp_data_ok = 1'b0;
            dbus.dresp_data    = {$urandom, $urandom};
            if (dbus.dreq_valid) begin
                if (obs_req - 1 == a) begin
                    dbus.dresp_addr_ok = 1'b1;
                    if (d == 0) begin dbus.dresp_data_ok = 1'b1; dbus.dresp_data = resp; end
                    else wait_cnt = d;
                end
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin dbus.dresp_data_ok = 1'b1; dbus.dresp_data = resp; end
            end
        end
        @(negedge clk);
        dbus.dresp_addr_ok = 1'b0;
        dbus.dresp_data_ok = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_memread = 1'b0; in_memwrite = 1'b0; in_regwrite = 1'b0;
        in_funct3 = 3'd0; in_dst = 5'd0; in_addr = 64'd0; in_wdata = 64'd0;
        dbus.dresp_addr_ok = 1'b0; dbus.dresp_data_ok = 1'b0; dbus.dresp_data = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_checks++; if ({dbus.dreq_valid, out_valid, stall_req, misalign, fwd_valid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got %b exp 00000", {dbus.dreq_valid, out_valid, stall_req, misalign, fwd_valid}); end
        n_checks++; if ({out_regwrite, out_dst, out_data} !== 70'd0) begin
            n_fail++; $display("FAIL reset_out_bundle got %h exp 0", {out_regwrite, out_dst, out_data}); end
        n_checks++; if ({dbus.dreq_write, dbus.dreq_addr, dbus.dreq_strobe, dbus.dreq_data} !== 137'd0) begin
            n_fail++; $display("FAIL reset_dreq_bundle got %h exp 0", {dbus.dreq_write, dbus.dreq_addr, dbus.dreq_strobe, dbus.dreq_data}); end
        reset = 1'b0;
    endtask

    task automatic test_alu;
        run_op(1'b0, 1'b0, 1'b1, 3'd0, 5'd5, 64'h1234, 64'd0, 0, 0, 64'd0);
        n_checks++; if (obs_vcyc !== 1) begin n_fail++; $display("FAIL alu_valid_cycle got %0d exp 1", obs_vcyc); end
        n_checks++; if (obs_pulses !== 1) begin n_fail++; $display("FAIL alu_pulses got %0d exp 1", obs_pulses); end
        n_checks++; if (obs_data !== 64'h1234) begin n_fail++; $display("FAIL alu_data got %h exp 1234", obs_data); end
        n_checks++; if (obs_dst !== 5'd5 || obs_rw !== 1'b1) begin n_fail++; $display("FAIL alu_dst_rw got %0d/%b exp 5/1", obs_dst, obs_rw); end
        n_checks++; if (obs_fwd !== 1'b1 || obs_fwd_data !== 64'h1234 || obs_fwd_dst !== 5'd5) begin
            n_fail++; $display("FAIL alu_fwd got %b/%0d/%h exp 1/5/1234", obs_fwd, obs_fwd_dst, obs_fwd_data); end
        n_checks++; if (obs_req !== 0) begin n_fail++; $display("FAIL alu_no_req got %0d exp 0", obs_req); end
    endtask

    task automatic test_lb;
        run_op(1'b1, 1'b0, 1'b1, 3'b000, 5'd7, 64'h1003, 64'd0, 0, 0, 64'h0000_0000_8000_0000);
        n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL lb_ready got %b exp 1", obs_ready); end
        n_checks++; if (obs_vcyc !== 2) begin n_fail++; $display("FAIL lb_valid_cycle got %0d exp 2", obs_vcyc); end
        n_checks++; if (obs_data !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL lb_data got %h exp ffffffffffffff80", obs_data); end
        n_checks++; if (obs_req !== 1 || obs_daddr !== 64'h1000 || obs_strobe !== 8'h00 || obs_write !== 1'b0) begin
            n_fail++; $display("FAIL lb_req got %0d/%h/%h/%b exp 1/1000/00/0", obs_req, obs_daddr, obs_strobe, obs_write); end
        n_checks++; if (obs_stall !== 1) begin n_fail++; $display("FAIL lb_stall got %0d exp 1", obs_stall); end
    endtask

    task automatic test_sh;
        run_op(1'b0, 1'b1, 1'b1, 3'b001, 5'd9, 64'h2006, 64'hBEEF, 0, 1, 64'd0);
        n_checks++; if (obs_daddr !== 64'h2000) begin n_fail++; $display("FAIL sh_addr got %h exp 2000", obs_daddr); end
        n_checks++; if (obs_strobe !== 8'hC0) begin n_fail++; $display("FAIL sh_strobe got %h exp c0", obs_strobe); end
        n_checks++; if (obs_ddata !== 64'hBEEF_0000_0000_0000) begin n_fail++; $display("FAIL sh_data got %h exp beef000000000000", obs_ddata); end
        n_checks++; if (obs_write !== 1'b1) begin n_fail++; $display("FAIL sh_write got %b exp 1", obs_write); end
        n_checks++; if (obs_vcyc !== 3 || obs_rw !== 1'b0 || obs_fwd !== 1'b0) begin
            n_fail++; $display("FAIL sh_done got %0d/%b/%b exp 3/0/0", obs_vcyc, obs_rw, obs_fwd); end
    endtask

    task automatic test_lw_stall;
        logic [63:0] resp;
        resp = 64'h1234_5678_9ABC_DEF0;
        run_op(1'b1, 1'b0, 1'b1, 3'b010, 5'd3, 64'h4004, 64'd0, 3, 2, resp);
        n_checks++; if (obs_changed !== 1'b0) begin n_fail++; $display("FAIL lw_req_stable got %b exp 0", obs_changed); end
        n_checks++; if (obs_req !== 4) begin n_fail++; $display("FAIL lw_req_cycles got %0d exp 4", obs_req); end
        n_checks++; if (obs_stall !== 6) begin n_fail++; $display("FAIL lw_stall_cycles got %0d exp 6", obs_stall); end
        n_checks++; if (obs_pulses !== 1 || obs_vcyc !== 7) begin n_fail++; $display("FAIL lw_valid got %0d@%0d exp 1@7", obs_pulses, obs_vcyc); end
        n_checks++; if (obs_data !== 64'h0000_0000_1234_5678) begin n_fail++; $display("FAIL lw_data got %h exp 12345678", obs_data); end
    endtask

    task automatic test_misalign;
        run_op(1'b1, 1'b0, 1'b1, 3'b011, 5'd4, 64'h3004, 64'd0, 0, 0, 64'd0);
        n_checks++; if (obs_mis !== 1 || obs_mis_cyc !== 1) begin n_fail++; $display("FAIL ld_misalign got %0d@%0d exp 1@1", obs_mis, obs_mis_cyc); end
        n_checks++; if (obs_req !== 0) begin n_fail++; $display("FAIL ld_no_req got %0d exp 0", obs_req); end
        n_checks++; if (obs_vcyc !== 1 || obs_rw !== 1'b0 || obs_fwd !== 1'b0) begin
            n_fail++; $display("FAIL ld_drop got %0d/%b/%b exp 1/0/0", obs_vcyc, obs_rw, obs_fwd); end
        run_op(1'b0, 1'b0, 1'b1, 3'd0, 5'd0, 64'h55, 64'd0, 0, 0, 64'd0);
        n_checks++; if (obs_vcyc !== 1 || obs_fwd !== 1'b0 || obs_mis !== 0) begin
            n_fail++; $display("FAIL dst0_fwd got %0d/%b/%0d exp 1/0/0", obs_vcyc, obs_fwd, obs_mis); end
    endtask

    task automatic test_reset_mid;
        int pulses;
        @(negedge clk);
        in_valid = 1'b1; in_memread = 1'b1; in_memwrite = 1'b0; in_regwrite = 1'b1;
        in_funct3 = 3'b010; in_dst = 5'd6; in_addr = 64'h5000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dbus.dresp_addr_ok = 1'b1; dbus.dresp_data_ok = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dbus.dresp_addr_ok = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL wait_stall got %b exp 1", stall_req); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dbus.dresp_data_ok = 1'b1; dbus.dresp_data = {$urandom, $urandom};
        #1;
        n_checks++; if (in_ready !== 1'b1 || dbus.dreq_valid !== 1'b0 || stall_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_state got %b%b%b exp 100", in_ready, dbus.dreq_valid, stall_req); end
        n_checks++; if (out_data !== 64'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_out got %h/%b exp 0/0", out_data, out_valid); end
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            dbus.dresp_data_ok = 1'b0;
            #1;
            if (out_valid) pulses++;
        end
        n_checks++; if (pulses !== 0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL stray_data_ok got %0d pulses ready %b exp 0/1", pulses, in_ready); end
    endtask

    task automatic test_random;
        logic        rd, wr, rw, is_mem, bad, mis, bus, exp_rw;
        logic [2:0]  f3;
        logic [4:0]  dst;
        logic [63:0] addr, wdata, resp, exp_data;
        int          a, d, sz, exp_vcyc;
        for (int i = 0; i < 60; i++) begin
            case ($urandom % 3)
                0:       begin rd = 1'b0; wr = 1'b0; end
                1:       begin rd = 1'b1; wr = ($urandom % 4 == 0); end
                default: begin rd = 1'b0; wr = 1'b1; end
            endcase
            if (rd) f3 = 3'($urandom % 8);
            else f3 = ($urandom % 8 == 0) ? 3'd7 : 3'($urandom % 4);
            rw = 1'($urandom); dst = 5'($urandom);
            addr = {$urandom, $urandom}; wdata = {$urandom, $urandom}; resp = {$urandom, $urandom};
            sz = 1 << f3[1:0];
            if ($urandom % 4 != 0) addr = addr - (addr % 64'(sz));
            a = $urandom % 4; d = $urandom % 4;
            is_mem = rd | wr;
            bad = (f3 == 3'd7);
            mis = is_mem && !bad && (addr % 64'(sz) != 0);
            bus = is_mem && !bad && !mis;
            exp_vcyc = bus ? 2 + a + d : 1;
            exp_rw = is_mem ? (bus && rd && rw) : rw;
            exp_data = is_mem ? exp_load(resp, addr, f3) : addr;
            run_op(rd, wr, rw, f3, dst, addr, wdata, a, d, resp);
            n_checks++; if (obs_vcyc !== exp_vcyc || obs_pulses !== 1) begin
                n_fail++; $display("FAIL rnd%0d valid got %0d@%0d exp 1@%0d", i, obs_pulses, obs_vcyc, exp_vcyc); end
            n_checks++; if (obs_rw !== exp_rw || obs_dst !== dst) begin
                n_fail++; $display("FAIL rnd%0d rw_dst got %b/%0d exp %b/%0d", i, obs_rw, obs_dst, exp_rw, dst); end
            n_checks++; if (obs_fwd !== (exp_rw && dst != 5'd0)) begin
                n_fail++; $display("FAIL rnd%0d fwd got %b exp %b", i, obs_fwd, exp_rw && dst != 5'd0); end
            n_checks++; if (obs_mis !== int'(mis) || obs_req !== (bus ? a + 1 : 0) || obs_stall !== (bus ? 1 + a + d : 0)) begin
                n_fail++; $display("FAIL rnd%0d mis_req_stall got %0d/%0d/%0d exp %0d/%0d/%0d", i, obs_mis, obs_req, obs_stall,
                                   mis, bus ? a + 1 : 0, bus ? 1 + a + d : 0); end
            if (!is_mem || (bus && rd)) begin
                n_checks++; if (obs_data !== exp_data) begin
                    n_fail++; $display("FAIL rnd%0d data got %h exp %h", i, obs_data, exp_data); end
            end
            if (bus) begin
                n_checks++; if (obs_daddr !== addr - (addr % 64'd8) || obs_write !== (wr && !rd) || obs_changed !== 1'b0) begin
                    n_fail++; $display("FAIL rnd%0d req got %h/%b/%b exp %h/%b/0", i, obs_daddr, obs_write, obs_changed,
                                       addr - (addr % 64'd8), wr && !rd); end
                if (wr && !rd) begin
                    n_checks++; if (obs_strobe !== exp_strobe(addr, f3) || obs_ddata !== (wdata << (8 * (addr % 64'd8)))) begin
                        n_fail++; $display("FAIL rnd%0d store got %h/%h exp %h/%h", i, obs_strobe, obs_ddata,
                                           exp_strobe(addr, f3), wdata << (8 * (addr % 64'd8))); end
                end else begin
                    n_checks++; if (obs_strobe !== 8'h00) begin
                        n_fail++; $display("FAIL rnd%0d load_strobe got %h exp 00", i, obs_strobe); end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_lb;
        test_sh;
        test_lw_stall;
        test_misalign;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
